ntlm_pad_driver: RTL and testbench



---
 rtl/ntlm_pkg.sv | 59 +++++
 rtl/ntlm_block_builder.sv | 93 +++++++++
 rtl/ntlm_pad_driver.sv | 200 ++++++++++++++++++++
 tb/tb_ntlm_pad_driver.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntlm_pkg.sv
// ----------------------------------------------------------------------------
// ntlm_pkg
// Shared constants, state encoding and helpers for the NT-hash pad driver
// and the MD4 block engine it feeds.
//
// Contents:
//   MD4_IV_A..D   - MD4 initial chaining values
//   LEN_BYTE_LO/HI - byte offsets of the 16-bit message bit length
//   PAD_BYTE      - the 0x80 terminator written right after the message
//   ntlm_state_e  - pad-driver state enumeration
//   ST_*          - plain localparam copies of the states for logic regs
//   bswap32       - 32-bit byte reversal (also used by the engine's
//                   byteswap include)
// ----------------------------------------------------------------------------
package ntlm_pkg;

    // MD4 initial chaining values (A, B, C, D)
    localparam logic [31:0] MD4_IV_A = 32'h67452301;
    localparam logic [31:0] MD4_IV_B = 32'hEFCDAB89;
    localparam logic [31:0] MD4_IV_C = 32'h98BADCFE;
    localparam logic [31:0] MD4_IV_D = 32'h10325476;

    // The message is at most 54 bytes, so its bit length never exceeds
    // 16 bits and only these two length bytes are ever non-zero.
    localparam int LEN_BYTE_LO = 56;
    localparam int LEN_BYTE_HI = 57;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    localparam int BLOCK_BYTES = 64;

    typedef enum logic [2:0] {
        FLUSH  = 3'd0,
        IDLE   = 3'd1,
        FILL   = 3'd2,
        PAD    = 3'd3,
        LAUNCH = 3'd4,
        WAIT   = 3'd5,
        DONE   = 3'd6,
        GAP    = 3'd7
    } ntlm_state_e;

    // Flat constants so the state register can stay a plain logic vector,
    // which keeps older tools and netlist viewers happy.
    localparam logic [2:0] ST_FLUSH  = FLUSH;
    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_FILL   = FILL;
    localparam logic [2:0] ST_PAD    = PAD;
    localparam logic [2:0] ST_LAUNCH = LAUNCH;
    localparam logic [2:0] ST_WAIT   = WAIT;
    localparam logic [2:0] ST_DONE   = DONE;
    localparam logic [2:0] ST_GAP    = GAP;

    // MD4 works on little-endian words, the digest is printed big-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/ntlm_block_builder.sv
// ----------------------------------------------------------------------------
// ntlm_block_builder
// Holds the 512-bit MD4 message block and applies the byte writes used while
// expanding a password to UTF-16LE and while appending the MD4 padding.
// Message byte k lives at o_block[511-8k -: 8].
//
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset, clears the block
//   i_clear    - clear the whole block (start of a new candidate)
//   i_fillEn   - write i_char to byte 2*i_charIdx and 00 to byte 2*i_charIdx+1
//   i_charIdx  - character index for the fill write
//   i_char     - ASCII character for the fill write
//   i_padEn    - write 0x80 at byte 2*i_len and the bit length at bytes 56/57
//   i_len      - message length in characters (already clamped)
//   o_block    - current message block
// ----------------------------------------------------------------------------
module ntlm_block_builder
    import ntlm_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_fillEn,
    input  logic [4:0]   i_charIdx,
    input  logic [7:0]   i_char,
    input  logic         i_padEn,
    input  logic [4:0]   i_len,
    output logic [511:0] o_block
);

    logic [511:0] r_block;
    logic [511:0] w_blockNext;
    logic [5:0]   w_fillLoIdx;
    logic [5:0]   w_fillHiIdx;
    logic [5:0]   w_padIdx;
    logic [8:0]   w_bitLen;
    logic [7:0]   w_lenLo;
    logic [7:0]   w_lenHi;

    // Byte addresses for the current write. Each UTF-16LE code unit takes
    // two bytes, so character i lands on byte 2i with a zero high byte.
    // The bit length is 16*len, which at most 432 fits in nine bits.
    always_comb begin
        w_fillLoIdx = {i_charIdx, 1'b0};
        w_fillHiIdx = {i_charIdx, 1'b1};
        w_padIdx    = {i_len, 1'b0};
        w_bitLen    = {i_len, 4'b0000};
        w_lenLo     = w_bitLen[7:0];
        w_lenHi     = {7'b0000000, w_bitLen[8]};
    end

    // Next-block computation: every byte keeps its value unless one of the
    // write strobes addresses it. Clearing wins over any write so a new
    // candidate always starts from an all-zero block.
    always_comb begin
        w_blockNext = r_block;
        if (i_clear) begin
            w_blockNext = '0;
        end else begin
            for (int k = 0; k < BLOCK_BYTES; k++) begin
                if (i_fillEn && (6'(k) == w_fillLoIdx)) begin
                    w_blockNext[511-8*k -: 8] = i_char;
                end
                if (i_fillEn && (6'(k) == w_fillHiIdx)) begin
                    w_blockNext[511-8*k -: 8] = 8'h00;
                end
                if (i_padEn && (6'(k) == w_padIdx)) begin
                    w_blockNext[511-8*k -: 8] = PAD_BYTE;
                end
                if (i_padEn && (k == LEN_BYTE_LO)) begin
                    w_blockNext[511-8*k -: 8] = w_lenLo;
                end
                if (i_padEn && (k == LEN_BYTE_HI)) begin
                    w_blockNext[511-8*k -: 8] = w_lenHi;
                end
            end
        end
    end

    // Block storage. The engine reads this combinationally for its whole
    // run, so it only ever changes under an explicit strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_block <= '0;
        end else begin
            r_block <= w_blockNext;
        end
    end

    assign o_block = r_block;

endmodule

// File: rtl/ntlm_pad_driver.sv
// ----------------------------------------------------------------------------
// ntlm_pad_driver
// Front end of the NT-hash pipeline: takes an ASCII candidate, expands it to
// UTF-16LE, builds the single padded MD4 block, launches the MD4 engine with
// the standard IV and returns the digest in canonical byte order.
//
// Parameters:
//   MAX_LEN      - maximum password length (1..27)
//   FLUSH_CYCLES - idle cycles after reset before the first launch (>= 54)
//
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   pw_valid/pw_ready       - candidate handshake
//   pw_data, pw_len         - candidate characters and length
//   md4_irdy                - one-cycle launch pulse to the engine
//   md4_state_a..d          - constant MD4 IV
//   md4_data                - 512-bit message block
//   md4_ordy                - engine done (held two cycles)
//   md4_newstate_a..d       - engine result
//   hash_valid, hash        - one-cycle result pulse and NT hash
//   busy                    - high in every state except IDLE
//
// Optional feature (macro NTPAD_TARGET_CMP_EN):
//   target_hash             - hash to compare against
//   match                   - pulses with hash_valid when hash == target_hash
// ----------------------------------------------------------------------------
module ntlm_pad_driver
    import ntlm_pkg::*;
#(
    parameter int MAX_LEN      = 27,
    parameter int FLUSH_CYCLES = 56
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pw_valid,
    output logic                 pw_ready,
    input  logic [8*MAX_LEN-1:0] pw_data,
    input  logic [4:0]           pw_len,
    output logic                 md4_irdy,
    output logic [31:0]          md4_state_a,
    output logic [31:0]          md4_state_b,
    output logic [31:0]          md4_state_c,
    output logic [31:0]          md4_state_d,
    output logic [511:0]         md4_data,
    input  logic                 md4_ordy,
    input  logic [31:0]          md4_newstate_a,
    input  logic [31:0]          md4_newstate_b,
    input  logic [31:0]          md4_newstate_c,
    input  logic [31:0]          md4_newstate_d,
    output logic                 hash_valid,
    output logic [127:0]         hash,
    output logic                 busy
`ifdef NTPAD_TARGET_CMP_EN
    ,
    input  logic [127:0]         target_hash,
    output logic                 match
`endif
);

    localparam int         CNT_W     = $clog2(FLUSH_CYCLES + 1);
    localparam logic [4:0] MAX_LEN_L = 5'(MAX_LEN);

    logic [2:0]           r_state;
    logic [2:0]           w_stateNext;
    logic [CNT_W-1:0]     r_flushCnt;
    logic [8*MAX_LEN-1:0] r_pwData;
    logic [4:0]           r_len;
    logic [4:0]           r_charIdx;
    logic                 r_pwReady;
    logic                 r_irdy;
    logic                 r_hashValid;
    logic [127:0]         r_hash;

    logic                 w_accept;
    logic [4:0]           w_lenClamped;
    logic                 w_lastChar;
    logic                 w_capture;
    logic [7:0]           w_charBit;
    logic [7:0]           w_char;
    logic                 w_clear;
    logic                 w_fillEn;
    logic                 w_padEn;
    logic [127:0]         w_hashNext;

    // Handshake qualification, length clamping and the character currently
    // being expanded. Lengths above MAX_LEN are clamped rather than rejected
    // so a misbehaving source can never push the padding past byte 55.
    always_comb begin
        w_accept     = (r_state == ST_IDLE) && r_pwReady && pw_valid;
        w_lenClamped = (pw_len > MAX_LEN_L) ? MAX_LEN_L : pw_len;
        w_lastChar   = (r_charIdx == (r_len - 5'd1));
        w_capture    = (r_state == ST_WAIT) && md4_ordy;
        w_charBit    = {r_charIdx, 3'b000};
        w_char       = r_pwData[w_charBit +: 8];
        w_clear      = w_accept;
        w_fillEn     = (r_state == ST_FILL);
        w_padEn      = (r_state == ST_PAD);
        w_hashNext   = {bswap32(md4_newstate_a), bswap32(md4_newstate_b),
                        bswap32(md4_newstate_c), bswap32(md4_newstate_d)};
    end

    // Next-state logic. FLUSH exists because the engine has no reset and can
    // still be finishing a run launched before our reset; we sit out long
    // enough for that run to end. GAP waits out the second ordy cycle so one
    // engine result is never captured twice.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_FLUSH:  if (r_flushCnt <= CNT_W'(1)) w_stateNext = ST_IDLE;
            ST_IDLE:   if (w_accept) w_stateNext = (w_lenClamped == 5'd0) ? ST_PAD : ST_FILL;
            ST_FILL:   if (w_lastChar) w_stateNext = ST_PAD;
            ST_PAD:    w_stateNext = ST_LAUNCH;
            ST_LAUNCH: w_stateNext = ST_WAIT;
            ST_WAIT:   if (md4_ordy) w_stateNext = ST_DONE;
            ST_DONE:   w_stateNext = ST_GAP;
            ST_GAP:    if (!md4_ordy) w_stateNext = ST_IDLE;
            default:   w_stateNext = ST_FLUSH;
        endcase
    end

    // Main sequential block: state, registered handshake/strobe outputs,
    // candidate latch, character counter and hash capture. The strobes are
    // decoded from the next state so they line up exactly with the state
    // they belong to while still coming straight out of flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FLUSH;
            r_flushCnt  <= CNT_W'(FLUSH_CYCLES);
            r_pwReady   <= 1'b0;
            r_irdy      <= 1'b0;
            r_hashValid <= 1'b0;
            r_hash      <= '0;
            r_pwData    <= '0;
            r_len       <= 5'd0;
            r_charIdx   <= 5'd0;
        end else begin
            r_state     <= w_stateNext;
            r_pwReady   <= (w_stateNext == ST_IDLE);
            r_irdy      <= (w_stateNext == ST_LAUNCH);
            r_hashValid <= (w_stateNext == ST_DONE);

            if (r_state == ST_FLUSH) begin
                r_flushCnt <= r_flushCnt - CNT_W'(1);
            end

            if (w_accept) begin
                r_pwData  <= pw_data;
                r_len     <= w_lenClamped;
                r_charIdx <= 5'd0;
            end else if (w_fillEn && !w_lastChar) begin
                r_charIdx <= r_charIdx + 5'd1;
            end

            if (w_capture) begin
                r_hash <= w_hashNext;
            end
        end
    end

`ifdef NTPAD_TARGET_CMP_EN
    logic r_match;

    // Target comparison is done on the incoming engine result in the same
    // cycle the hash is captured, so match rises together with hash_valid
    // and drops with it one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match <= 1'b0;
        end else begin
            r_match <= w_capture && (w_hashNext == target_hash);
        end
    end

    assign match = r_match;
`endif

    ntlm_block_builder u_builder (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_fillEn  (w_fillEn),
        .i_charIdx (r_charIdx),
        .i_char    (w_char),
        .i_padEn   (w_padEn),
        .i_len     (r_len),
        .o_block   (md4_data)
    );

    assign pw_ready    = r_pwReady;
    assign md4_irdy    = r_irdy;
    assign hash_valid  = r_hashValid;
    assign hash        = r_hash;
    assign busy        = (r_state != ST_IDLE);
    assign md4_state_a = MD4_IV_A;
    assign md4_state_b = MD4_IV_B;
    assign md4_state_c = MD4_IV_C;
    assign md4_state_d = MD4_IV_D;

endmodule

// File: tb/tb_ntlm_pad_driver.sv
// ----------------------------------------------------------------------------
// tb_ntlm_pad_driver
// Directed bench for ntlm_pad_driver. A behavioural MD4 engine answers each
// launch 52 cycles later with a two-cycle ordy. Expected blocks and hashes are
// queued when a candidate is offered and checked by independent monitors.
// Define NTPAD_TARGET_CMP_EN to also exercise the target comparator.
// ----------------------------------------------------------------------------
module tb_ntlm_pad_driver;

    localparam int MAX_LEN      = 27;
    localparam int FLUSH_CYCLES = 56;

    typedef struct {
        logic [127:0] hash;
        logic         match;
        int           cycle;
    } hashExp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pw_valid;
    logic                 pw_ready;
    logic [8*MAX_LEN-1:0] pw_data;
    logic [4:0]           pw_len;
    logic                 md4_irdy;
    logic [31:0]          md4_state_a, md4_state_b, md4_state_c, md4_state_d;
    logic [511:0]         md4_data;
    logic                 md4_ordy = 1'b0;
    logic [31:0]          md4_newstate_a = '0, md4_newstate_b = '0;
    logic [31:0]          md4_newstate_c = '0, md4_newstate_d = '0;
    logic                 hash_valid;
    logic [127:0]         hash;
    logic                 busy;
`ifdef NTPAD_TARGET_CMP_EN
    logic [127:0]         target_hash;
    logic                 match;
`endif

    int           testsRun    = 0;
    int           testsFailed = 0;
    int           cycleCnt    = 0;
    int           engCnt      = 0;
    logic         ordyTail    = 1'b0;
    logic [511:0] blkQ[$];
    hashExp_t     hashQ[$];

    ntlm_pad_driver #(.MAX_LEN(MAX_LEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk            (clk),
        .rst            (rst),
        .pw_valid       (pw_valid),
        .pw_ready       (pw_ready),
        .pw_data        (pw_data),
        .pw_len         (pw_len),
        .md4_irdy       (md4_irdy),
        .md4_state_a    (md4_state_a),
        .md4_state_b    (md4_state_b),
        .md4_state_c    (md4_state_c),
        .md4_state_d    (md4_state_d),
        .md4_data       (md4_data),
        .md4_ordy       (md4_ordy),
        .md4_newstate_a (md4_newstate_a),
        .md4_newstate_b (md4_newstate_b),
        .md4_newstate_c (md4_newstate_c),
        .md4_newstate_d (md4_newstate_d),
        .hash_valid     (hash_valid),
        .hash           (hash),
        .busy           (busy)
`ifdef NTPAD_TARGET_CMP_EN
        ,
        .target_hash    (target_hash),
        .match          (match)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic logic [31:0] tbSwap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    // Reference MD4 compression of one block starting from the standard IV
    function automatic logic [127:0] md4Compress(input logic [511:0] blk);
        logic [31:0] x[16];
        logic [31:0] a, b, c, d, f, t, kc;
        logic [3:0]  jj;
        int          k, s;
        for (int j = 0; j < 16; j++)
            x[j] = {blk[511-8*(4*j+3) -: 8], blk[511-8*(4*j+2) -: 8],
                    blk[511-8*(4*j+1) -: 8], blk[511-8*(4*j) -: 8]};
        a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476;
        for (int i = 0; i < 48; i++) begin
            if (i < 16) begin
                f = (b & c) | (~b & d); k = i; kc = 32'h0;
                case (i % 4) 0: s = 3; 1: s = 7; 2: s = 11; default: s = 19; endcase
            end else if (i < 32) begin
                f = (b & c) | (b & d) | (c & d);
                k = ((i - 16) % 4) * 4 + (i - 16) / 4; kc = 32'h5A827999;
                case (i % 4) 0: s = 3; 1: s = 5; 2: s = 9; default: s = 13; endcase
            end else begin
                f = b ^ c ^ d; jj = 4'(i - 32);
                k = int'({jj[0], jj[1], jj[2], jj[3]}); kc = 32'h6ED9EBA1;
                case (i % 4) 0: s = 3; 1: s = 9; 2: s = 11; default: s = 15; endcase
            end
            t = rotl(a + f + x[k] + kc, s);
            a = d; d = c; c = b; b = t;
        end
        return {a + 32'h67452301, b + 32'hEFCDAB89, c + 32'h98BADCFE, d + 32'h10325476};
    endfunction

    function automatic logic [127:0] modelHash(input logic [511:0] blk);
        logic [127:0] h;
        h = md4Compress(blk);
        return {tbSwap(h[127:96]), tbSwap(h[95:64]), tbSwap(h[63:32]), tbSwap(h[31:0])};
    endfunction

    function automatic logic [8*MAX_LEN-1:0] packPw(input string s);
        logic [8*MAX_LEN-1:0] d;
        d = '0;
        for (int i = 0; i < s.len() && i < MAX_LEN; i++) d[8*i +: 8] = s[i];
        return d;
    endfunction

    // Expected padded UTF-16LE block for len characters of d
    function automatic logic [511:0] buildBlock(input logic [8*MAX_LEN-1:0] d, input int len);
        logic [511:0] blk;
        logic [15:0]  bits;
        blk = '0;
        for (int i = 0; i < len; i++) blk[511-16*i -: 8] = d[8*i +: 8];
        blk[511-16*len -: 8] = 8'h80;
        bits = 16'(len * 16);
        blk[511-8*56 -: 8] = bits[7:0];
        blk[511-8*57 -: 8] = bits[15:8];
        return blk;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural engine: samples the block just before answering, so any
    // change of md4_data during the run shows up as a wrong hash.
    always @(posedge clk) begin
        if (engCnt == 1) begin
            md4_ordy <= 1'b1;
            ordyTail <= 1'b1;
            {md4_newstate_a, md4_newstate_b, md4_newstate_c, md4_newstate_d} <= md4Compress(md4_data);
        end else if (ordyTail) begin
            ordyTail <= 1'b0;
        end else begin
            md4_ordy <= 1'b0;
        end
        if (md4_irdy) engCnt <= 52;
        else if (engCnt > 0) engCnt <= engCnt - 1;
    end

    // Block monitor: every launch cycle must match the next queued block
    always @(negedge clk) begin
        if (md4_irdy) begin
            checkOutput("launchExpected", 512'(blkQ.size() != 0), 512'(1));
            if (blkQ.size() != 0) checkOutput("md4Data", md4_data, blkQ.pop_front());
        end
    end

    // Hash monitor: every hash_valid must match the next queued result
    always @(negedge clk) begin
        hashExp_t e;
        if (hash_valid) begin
            checkOutput("hashValidExpected", 512'(hashQ.size() != 0), 512'(1));
            if (hashQ.size() != 0) begin
                e = hashQ.pop_front();
                checkOutput("hash", 512'(hash), 512'(e.hash));
                checkOutput("latency", 512'(cycleCnt), 512'(e.cycle));
`ifdef NTPAD_TARGET_CMP_EN
                checkOutput("match", 512'(match), 512'(e.match));
`endif
            end
        end
    end

    // Offer one candidate, queue its expected block and (optionally) hash,
    // then keep pw_valid high with junk for a few busy cycles.
    task automatic applyStimulus(input string pw, input logic [4:0] lenIn, input bit expectHash,
                                 input logic [127:0] expHash, input logic expMatch);
        hashExp_t e;
        int effLen, waitCnt;
        logic [8*MAX_LEN-1:0] d;
        waitCnt = 0;
        @(negedge clk);
        while (!pw_ready && waitCnt < 300) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!pw_ready) begin
            checkOutput("readyTimeout", 512'(pw_ready), 512'(1));
            return;
        end
        d = packPw(pw);
        effLen = (lenIn > 5'd27) ? 27 : int'(lenIn);
        pw_valid = 1'b1;
        pw_data  = d;
        pw_len   = lenIn;
        blkQ.push_back(buildBlock(d, effLen));
        if (expectHash) begin
            e.hash  = expHash;
            e.match = expMatch;
            e.cycle = cycleCnt + 1 + effLen + 55;
            hashQ.push_back(e);
        end
        @(negedge clk);
        pw_data = '1;
        pw_len  = 5'd3;
        repeat (3) @(negedge clk);
        pw_valid = 1'b0;
    endtask

    // Called on the negedge right after the reset edge; counts pw_ready-low
    // cycles including this one.
    task automatic countFlush();
        int cnt;
        cnt = 1;
        checkOutput("flushBusy", 512'(busy), 512'(1));
        while (!pw_ready && cnt < 200) begin
            @(negedge clk);
            if (!pw_ready) begin
                cnt++;
                if (md4_irdy || hash_valid) checkOutput("flushQuiet", 512'({md4_irdy, hash_valid}), 512'(0));
            end
        end
        checkOutput("flushCycles", 512'(cnt), 512'(FLUSH_CYCLES));
    endtask

    initial begin
        string a27;
        int drain;
        a27 = "";
        for (int i = 0; i < 27; i++) a27 = {a27, "A"};
        rst = 1'b1; pw_valid = 1'b0; pw_data = '0; pw_len = 5'd0;
`ifdef NTPAD_TARGET_CMP_EN
        target_hash = 128'h8846f7eaee8fb117ad06bdd830b7586c;
`endif
        repeat (3) @(negedge clk);
        checkOutput("rstReady", 512'(pw_ready), 512'(0));
        checkOutput("rstIrdy", 512'(md4_irdy), 512'(0));
        checkOutput("rstHashValid", 512'(hash_valid), 512'(0));
        checkOutput("rstHash", 512'(hash), 512'(0));
        checkOutput("rstData", md4_data, 512'(0));
        checkOutput("rstBusy", 512'(busy), 512'(1));
        checkOutput("ivA", 512'(md4_state_a), 512'(32'h67452301));
        checkOutput("ivB", 512'(md4_state_b), 512'(32'hEFCDAB89));
        checkOutput("ivC", 512'(md4_state_c), 512'(32'h98BADCFE));
        checkOutput("ivD", 512'(md4_state_d), 512'(32'h10325476));
        rst = 1'b0;
        countFlush();
        checkOutput("idleBusy", 512'(busy), 512'(0));

        applyStimulus("", 5'd0, 1'b1, 128'h31d6cfe0d16ae931b73c59d7e0c089c0, 1'b0);
        applyStimulus("password", 5'd8, 1'b1, 128'h8846f7eaee8fb117ad06bdd830b7586c, 1'b1);
        applyStimulus(a27, 5'd27, 1'b1, modelHash(buildBlock(packPw(a27), 27)), 1'b0);
        applyStimulus(a27, 5'd31, 1'b1, modelHash(buildBlock(packPw(a27), 27)), 1'b0);

        // Abort a run while the engine is busy; its late ordy must be ignored
        applyStimulus("password", 5'd8, 1'b0, 128'h0, 1'b0);
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortHash", 512'(hash), 512'(0));
        checkOutput("abortData", md4_data, 512'(0));
        countFlush();
        applyStimulus("password", 5'd8, 1'b1, 128'h8846f7eaee8fb117ad06bdd830b7586c, 1'b1);
`ifdef NTPAD_TARGET_CMP_EN
        applyStimulus("Password", 5'd8, 1'b1, modelHash(buildBlock(packPw("Password"), 8)), 1'b0);
`endif

        drain = 0;
        while ((blkQ.size() != 0 || hashQ.size() != 0) && drain < 500) begin
            @(negedge clk);
            drain++;
        end
        repeat (5) @(negedge clk);
        checkOutput("blkQEmpty", 512'(blkQ.size()), 512'(0));
        checkOutput("hashQEmpty", 512'(hashQ.size()), 512'(0));
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
